logic_pipe_unit: RTL

- Parametrised, registered successor to the combinational 8-bit bitwise logic block.
- One DATA_W-bit bitwise operation per transaction, selected by opcode. Operand B comes from an input or from an internal accumulator.
- Two-stage valid/ready pipeline. Stage 2 adds result flags: zero, popcount, parity.
- Transaction counter for debug. Sits between a stream source and a stream sink in the demo datapath.

---
 rtl/logic_pipe_unit_if.sv | 40 ++++
 rtl/logic_pipe_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/logic_pipe_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : logic_pipe_unit_if
// Brief    : Stream-in / stream-out bundle for the pipelined logic unit.
// Revision : 1.0 - initial release
// ============================================================================
interface logic_pipe_unit_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    localparam int ONES_W = $clog2(DATA_W + 1);

    logic              pi_valid;
    logic              po_ready;
    logic [2:0]        pi_op;
    logic              pi_acc_mode;
    logic              pi_acc_clr;
    logic [DATA_W-1:0] pi_a;
    logic [DATA_W-1:0] pi_b;
    logic              po_valid;
    logic              pi_ready;
    logic [DATA_W-1:0] po_res;
    logic              po_zero;
    logic [ONES_W-1:0] po_ones;
    logic              po_parity;
    logic [CNT_W-1:0]  po_cnt;
    logic [DATA_W-1:0] po_acc;

    // master drives transactions in and consumes results; slave is the unit
    modport master (
        output pi_valid, pi_op, pi_acc_mode, pi_acc_clr, pi_a, pi_b, pi_ready,
        input  po_ready, po_valid, po_res, po_zero, po_ones, po_parity, po_cnt, po_acc
    );

    modport slave (
        input  pi_valid, pi_op, pi_acc_mode, pi_acc_clr, pi_a, pi_b, pi_ready,
        output po_ready, po_valid, po_res, po_zero, po_ones, po_parity, po_cnt, po_acc
    );
endinterface
`default_nettype wire

// File: rtl/logic_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : logic_pipe_unit
// Brief    : Two-stage valid/ready bitwise logic unit with accumulator,
//            result flags and accepted-transaction counter.
// Revision : 1.0 - initial release
// ============================================================================
module logic_pipe_unit #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  wire logic        sys_clk,
    input  wire logic        sys_rst,
    logic_pipe_unit_if.slave bus
);
    localparam int ONES_W = $clog2(DATA_W + 1);

    localparam logic [2:0] c_OP_AND  = 3'd0;
    localparam logic [2:0] c_OP_OR   = 3'd1;
    localparam logic [2:0] c_OP_NAND = 3'd2;
    localparam logic [2:0] c_OP_NOR  = 3'd3;
    localparam logic [2:0] c_OP_XOR  = 3'd4;
    localparam logic [2:0] c_OP_XNOR = 3'd5;
    localparam logic [2:0] c_OP_NOTA = 3'd6;
    localparam logic [2:0] c_OP_PASS = 3'd7;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_res;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_res;
    logic              r_zero;
    logic [ONES_W-1:0] r_ones;
    logic              r_parity;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_acc;

    logic              w_s2_adv;
    logic              w_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_acc_eff;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_op_res;
    logic [ONES_W-1:0] w_ones;

    assign w_s2_adv = !r_s2_valid || bus.pi_ready;
    // Purely combinational so a downstream ready propagates in the same cycle
    assign w_ready  = !r_s1_valid || w_s2_adv;
    assign w_accept = bus.pi_valid && w_ready;

    // A clear arriving with an acc-mode transaction makes that operand zero
    assign w_acc_eff = bus.pi_acc_clr ? '0 : r_acc;
    assign w_b       = bus.pi_acc_mode ? w_acc_eff : bus.pi_b;

    always_comb begin
        w_op_res = '0;
        case (bus.pi_op)
            c_OP_AND:  w_op_res = bus.pi_a & w_b;
            c_OP_OR:   w_op_res = bus.pi_a | w_b;
            c_OP_NAND: w_op_res = ~(bus.pi_a & w_b);
            c_OP_NOR:  w_op_res = ~(bus.pi_a | w_b);
            c_OP_XOR:  w_op_res = bus.pi_a ^ w_b;
            c_OP_XNOR: w_op_res = ~(bus.pi_a ^ w_b);
            c_OP_NOTA: w_op_res = ~bus.pi_a;
            c_OP_PASS: w_op_res = bus.pi_a;
        endcase
    end

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_ones = w_ones + ONES_W'(r_s1_res[i]);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_res   <= '0;
            r_s2_valid <= 1'b0;
            r_res      <= '0;
            r_zero     <= 1'b0;
            r_ones     <= '0;
            r_parity   <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
        end else begin
            if (w_accept) begin
                r_s1_res   <= w_op_res;
                r_s1_valid <= 1'b1;
                r_acc      <= w_op_res;
                r_cnt      <= r_cnt + 1'b1;
            end else begin
                if (w_s2_adv) begin
                    r_s1_valid <= 1'b0;
                end
                if (bus.pi_acc_clr) begin
                    r_acc <= '0;
                end
            end

            // Result and flags only change when stage 2 advances, so they hold under stall
            if (w_s2_adv) begin
                if (r_s1_valid) begin
                    r_res      <= r_s1_res;
                    r_zero     <= (r_s1_res == '0);
                    r_ones     <= w_ones;
                    r_parity   <= ^r_s1_res;
                    r_s2_valid <= 1'b1;
                end else begin
                    r_s2_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.po_ready  = w_ready;
    assign bus.po_valid  = r_s2_valid;
    assign bus.po_res    = r_res;
    assign bus.po_zero   = r_zero;
    assign bus.po_ones   = r_ones;
    assign bus.po_parity = r_parity;
    assign bus.po_cnt    = r_cnt;
    assign bus.po_acc    = r_acc;
endmodule
`default_nettype wire
